// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with sign handling around an unsigned core.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} stateT;

    stateT              state, stateNext;
    logic [1:0]         opReg;
    logic [WIDTH-1:0]   srcAReg, srcBReg;
    logic [WIDTH-1:0]   aReg, bReg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               resNeg, remNeg;

    logic               isSigned, isDiv, aNeg, bNeg;
    logic [WIDTH:0]     mulSum, divTrial;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    assign isSigned = ~opReg[0];
    assign isDiv    = opReg[1];
    assign aNeg     = isSigned & srcAReg[WIDTH-1];
    assign bNeg     = isSigned & srcBReg[WIDTH-1];

    // Multiply builds the product in the upper half and shifts it down; divide
    // keeps the partial remainder in the lower half and shifts quotient bits into aReg.
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bReg[0] ? {1'b0, aReg} : '0);
    assign divTrial = {acc[WIDTH-1:0], aReg[WIDTH-1]} - {1'b0, bReg};

    assign prodFix  = resNeg ? -acc : acc;
    assign quoFix   = resNeg ? -aReg : aReg;
    assign remFix   = remNeg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    assign busy = (state == PREP) || (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = PREP;
            PREP:    stateNext = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opReg   <= '0;
            srcAReg <= '0;
            srcBReg <= '0;
            aReg    <= '0;
            bReg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            resNeg  <= 1'b0;
            remNeg  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg   <= op;
                        srcAReg <= srcA;
                        srcBReg <= srcB;
                    end else begin
                        if (mthi) hi <= srcA;
                        if (mtlo) lo <= srcA;
                    end
                end
                PREP: begin
                    aReg   <= aNeg ? -srcAReg : srcAReg;
                    bReg   <= bNeg ? -srcBReg : srcBReg;
                    resNeg <= aNeg ^ bNeg;
                    remNeg <= aNeg;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (isDiv) begin
                        if (!divTrial[WIDTH]) acc[WIDTH-1:0] <= divTrial[WIDTH-1:0];
                        else                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], aReg[WIDTH-1]};
                        aReg <= {aReg[WIDTH-2:0], ~divTrial[WIDTH]};
                    end else begin
                        acc  <= {mulSum, acc[WIDTH-1:1]};
                        bReg <= bReg >> 1;
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        // Zero divisor bypasses the sign fix-up: all-ones quotient, dividend as remainder.
                        if (srcBReg == '0) begin
                            lo <= '1;
                            hi <= srcAReg;
                        end else begin
                            lo <= quoFix;
                            hi <= remFix;
                        end
                    end else begin
                        {hi, lo} <= prodFix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
